vga_plot_arbiter: RTL and testbench
===================================

# vga_plot_arbiter

Shares the single VGA controller pixel-write port (x, y, colour, plot) between N independent drawing engines, such as bouncing-box animators and screen clearers. Engines request the port, receive it round-robin for a whole burst (one box draw or erase), and stream pixels through it. The arbiter sits between the engines' FSM/datapath pairs and the VGA controller, and is the only driver of the controller's plot inputs.

## Interface

**Parameters**
- N_REQ, 4: number of requesting engines (2–8).
- X_SCREENSIZE, 160: screen width; pixels with x ≥ this are dropped.
- Y_SCREENSIZE, 120: screen height; pixels with y ≥ this are dropped.
- MAX_BURST_CYCLES, 64: cycles a grant may be held; used only when the timeout feature is compiled in.

**Ports**
- iClock, in, 1: single clock. All logic is rising-edge.
- iResetn, in, 1: reset. Asynchronous, active-low.
- iReq, in, N_REQ: per-engine request. Held high for the whole burst.
- iX, in, N_REQ*8: packed pixel x. Engine i occupies [8i+7:8i].
- iY, in, N_REQ*7: packed pixel y. Engine i occupies [7i+6:7i].
- iColour, in, N_REQ*3: packed pixel colour. Engine i occupies [3i+2:3i].
- iValid, in, N_REQ: pixel beat valid.
- iLast, in, N_REQ: marks the final beat of a burst.
- oGrant, out, N_REQ: one-hot grant, registered.
- oReady, out, N_REQ: beat accepted when iValid[i] & oReady[i].
- oX, out, 8: to the VGA controller.
- oY, out, 7: to the VGA controller.
- oColour, out, 3: to the VGA controller.
- oPlot, out, 1: pixel write enable to the VGA controller.
- oBusy, out, 1: high while any grant is held.

## Operation

**FSM states:** S_IDLE, S_BURST.
- S_IDLE → S_BURST when any iReq bit is high. The grant goes to the first requester found searching upward (with wrap) from last_grant+1.
- S_BURST → S_IDLE on any of these:
  - an accepted beat with iLast high;
  - iReq[granted] dropping low (abandoned burst);
  - timeout, if compiled in.
- On every return to S_IDLE, last_grant is updated to the engine just served.

**Grant and ready:**
- oReady[i] = (state == S_BURST) & oGrant[i]. This is combinational from registers.
- Non-granted engines always see oReady = 0.

**Accepted beats:**
- Registered into oX/oY/oColour.
- oPlot = 1 on the next cycle only if x < X_SCREENSIZE and y < Y_SCREENSIZE. Otherwise the beat is consumed and oPlot stays 0.

**Round-robin fairness:** with all engines requesting continuously, each engine receives exactly one burst per N_REQ bursts.

**Reset and idle values:**
- Reset (asynchronous, any time, including mid-burst) forces:
  - state = S_IDLE
  - oGrant = 0
  - last_grant = N_REQ-1, so engine 0 wins first
  - oX = 0, oY = 0, oColour = 0
  - oPlot = 0, oBusy = 0
- Any in-flight beat is lost.
- oPlot is 0 in every cycle with no accepted in-range beat.

## Timing

- **Grant latency:** iReq sampled high in S_IDLE at edge t; oGrant/oBusy/oReady high from t+1.
- **Pixel latency:** a beat accepted at edge t appears on oX/oY/oColour/oPlot from t+1 for exactly one cycle. Throughput is one pixel per cycle.
- **End of burst:** a last beat accepted at edge t drops oGrant/oReady at t+1 (state S_IDLE). The earliest next grant is at t+2, which gives one idle cycle between bursts.
- **Simultaneous requests in S_IDLE:** resolved by the round-robin pointer only; the lower index has no fixed priority.
- **iValid low inside a burst:** a bubble. The grant is held and oPlot is 0 that cycle.
- **iLast without iValid:** ignored.

## Configuration

- **PLOT_ARB_TIMEOUT_EN defined:** a cycle counter clears on entry to S_BURST and increments each S_BURST cycle. When it reaches MAX_BURST_CYCLES-1, the grant is revoked at the next edge exactly as if iLast had been accepted. A beat presented in that final cycle is still accepted.
- **Not defined:** no counter is built and a burst may be held indefinitely. MAX_BURST_CYCLES is unused.

## Structure

- **Package vga_pkg:**
  - X_SCREENSIZE/Y_SCREENSIZE defaults
  - coordinate widths (8/7) and colour width (3)
  - FSM state encoding localparams S_IDLE/S_BURST
  - packed pixel typedef {x, y, colour}
- **Sub-module rr_pick:** purely combinational; inputs request vector and last_grant, output one-hot next grant. Instantiated once.
- **Top level:** FSM, pointer, optional timeout counter, and output registers.

## Test plan

- **Single burst:** reset; engine 0 requests with 16 beats (x=10..13, y=20..23), iLast on beat 16 → oGrant=0001 one cycle after iReq; 16 oPlot pulses with matching coordinates, each one cycle after acceptance; oBusy falls after the last beat.
- **Round-robin:** all four engines request with 4-beat bursts → grant order 0,1,2,3,0, with one idle cycle between bursts.
- **Clipping:** engine 2 sends x=159,y=119 then x=160,y=50 → the first pixel plots; the second is accepted (oReady) with oPlot=0.
- **Abandon and bubbles:** engine 1 drops iReq after 3 of 16 beats, with iValid low on beat 2 → oPlot absent for the bubble; grant released the cycle after iReq falls; engine 2 is granted next.
- **Mid-burst reset:** assert iResetn=0 asynchronously during a burst → oGrant/oPlot/oBusy go to 0 immediately; after release, engine 0 wins the next arbitration.
- **Timeout (PLOT_ARB_TIMEOUT_EN, MAX_BURST_CYCLES=8):** engine 3 streams without iLast → the grant drops after 8 S_BURST cycles with 8 accepted beats; the waiting engine 0 is granted 2 cycles later.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA plot-port arbiter.
// Coordinates follow the 160x120 3-bit-colour VGA adapter.
package vga_pkg;

    localparam int DEF_X_SCREENSIZE = 160;
    localparam int DEF_Y_SCREENSIZE = 120;

    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam int C_W = 3;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [C_W-1:0] colour;
    } pixel_t;

endpackage

// File: rtl/vga_plot_arbiter_rr_pick.sv
// Round-robin picker: first requester searching upward (with wrap)
// from last_grant+1; one-hot result, all-zero when nobody requests.
module rr_pick #(
    parameter int N_REQ = 4,
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_grant,
    output logic [N_REQ-1:0] grant
);

    logic          found;
    logic [IW-1:0] sel;

    always_comb begin
        grant = '0;
        found = 1'b0;
        sel   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            sel = IW'((32'(last_grant) + 32'(k)) % 32'(N_REQ));
            if (!found && req[sel]) begin
                grant[sel] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin burst arbiter for the VGA controller's pixel-write port.
// Define PLOT_ARB_TIMEOUT_EN to revoke grants after MAX_BURST_CYCLES.
module vga_plot_arbiter
    import vga_pkg::*;
#(
    parameter int N_REQ            = 4,
    parameter int X_SCREENSIZE     = DEF_X_SCREENSIZE,
    parameter int Y_SCREENSIZE     = DEF_Y_SCREENSIZE,
    parameter int MAX_BURST_CYCLES = 64
) (
    input  logic                 iClock,
    input  logic                 iResetn,
    input  logic [N_REQ-1:0]     iReq,
    input  logic [N_REQ*X_W-1:0] iX,
    input  logic [N_REQ*Y_W-1:0] iY,
    input  logic [N_REQ*C_W-1:0] iColour,
    input  logic [N_REQ-1:0]     iValid,
    input  logic [N_REQ-1:0]     iLast,
    output logic [N_REQ-1:0]     oGrant,
    output logic [N_REQ-1:0]     oReady,
    output logic [X_W-1:0]       oX,
    output logic [Y_W-1:0]       oY,
    output logic [C_W-1:0]       oColour,
    output logic                 oPlot,
    output logic                 oBusy
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
        $error("vga_plot_arbiter: N_REQ must be 2..8");
    end
    if (MAX_BURST_CYCLES < 1) begin : g_bad_burst
        $error("vga_plot_arbiter: MAX_BURST_CYCLES must be >= 1");
    end

    state_t            state, state_nxt;
    logic [N_REQ-1:0]  grant_q, grant_nxt, pick;
    logic [IW-1:0]     last_q, last_nxt, gidx;
    pixel_t            beat;
    logic              accept, in_range, done, tmo;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req        (iReq),
        .last_grant (last_q),
        .grant      (pick)
    );

    // Grant is one-hot, so a plain OR-scan yields the index and beat mux.
    always_comb begin
        gidx = '0;
        beat = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                gidx = IW'(i);
                beat = {iX[X_W*i +: X_W], iY[Y_W*i +: Y_W],
                        iColour[C_W*i +: C_W]};
            end
        end
    end

    assign oGrant   = grant_q;
    assign oReady   = (state == S_BURST) ? grant_q : '0;
    assign accept   = |(iValid & oReady);
    assign in_range = (32'(beat.x) < 32'(X_SCREENSIZE)) &&
                      (32'(beat.y) < 32'(Y_SCREENSIZE));
    assign done     = (accept & iLast[gidx]) | ~iReq[gidx] | tmo;

`ifdef PLOT_ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_BURST_CYCLES) + 1;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            cnt_q <= '0;
        end else if (state == S_IDLE) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tmo = (state == S_BURST) &&
                 (cnt_q == CW'(MAX_BURST_CYCLES - 1));
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_q;
        last_nxt  = last_q;
        unique case (state)
            S_IDLE: begin
                if (|iReq) begin
                    state_nxt = S_BURST;
                    grant_nxt = pick;
                end
            end
            S_BURST: begin
                if (done) begin
                    state_nxt = S_IDLE;
                    grant_nxt = '0;
                    last_nxt  = gidx;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            state   <= S_IDLE;
            grant_q <= '0;
            last_q  <= IW'(N_REQ - 1);
            oBusy   <= 1'b0;
        end else begin
            state   <= state_nxt;
            grant_q <= grant_nxt;
            last_q  <= last_nxt;
            oBusy   <= (state_nxt == S_BURST);
        end
    end

    // Out-of-screen beats are still consumed, they just never plot.
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            oX      <= '0;
            oY      <= '0;
            oColour <= '0;
            oPlot   <= 1'b0;
        end else begin
            oPlot <= accept & in_range;
            if (accept) begin
                oX      <= beat.x;
                oY      <= beat.y;
                oColour <= beat.colour;
            end
        end
    end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Randomized scoreboard bench for vga_plot_arbiter.
// Reference model tracks who should own the port and which pixels plot.
module tb_vga_plot_arbiter;

    localparam int N   = 4;
    localparam int XS  = 160;
    localparam int YS  = 120;
    localparam int MBC = 8;

    logic           iClock = 1'b0;
    logic           iResetn = 1'b0;
    logic [N-1:0]   iReq = '0;
    logic [N*8-1:0] iX = '0;
    logic [N*7-1:0] iY = '0;
    logic [N*3-1:0] iColour = '0;
    logic [N-1:0]   iValid = '0;
    logic [N-1:0]   iLast = '0;
    logic [N-1:0]   oGrant, oReady;
    logic [7:0]     oX;
    logic [6:0]     oY;
    logic [2:0]     oColour;
    logic           oPlot, oBusy;

    always #5 iClock = ~iClock;

    vga_plot_arbiter #(
        .N_REQ            (N),
        .X_SCREENSIZE     (XS),
        .Y_SCREENSIZE     (YS),
        .MAX_BURST_CYCLES (MBC)
    ) dut (
        .iClock  (iClock),
        .iResetn (iResetn),
        .iReq    (iReq),
        .iX      (iX),
        .iY      (iY),
        .iColour (iColour),
        .iValid  (iValid),
        .iLast   (iLast),
        .oGrant  (oGrant),
        .oReady  (oReady),
        .oX      (oX),
        .oY      (oY),
        .oColour (oColour),
        .oPlot   (oPlot),
        .oBusy   (oBusy)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: owner of the port, round-robin pointer, pixel queue.
    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    pix_t         exp_q[$];
    bit           m_busy = 0;
    int           m_eng = 0;
    int           m_ptr = N - 1;
    int           m_cnt = 0;
    bit           exp_plot = 0;
    logic [N-1:0] exp_grant = '0;

    always @(posedge iClock) begin
        if (!iResetn) begin
            m_busy   = 0;
            m_ptr    = N - 1;
            m_cnt    = 0;
            exp_plot = 0;
            exp_q.delete();
        end else begin
            exp_plot = 0;
            if (!m_busy) begin
                if (iReq != '0) begin
                    bit found;
                    found = 0;
                    for (int k = 1; k <= N; k++) begin
                        int j;
                        j = (m_ptr + k) % N;
                        if (!found && iReq[j]) begin
                            m_eng = j;
                            found = 1;
                        end
                    end
                    m_busy = 1;
                    m_cnt  = 0;
                end
            end else begin
                bit fin;
                fin = 0;
                if (iValid[m_eng]) begin
                    pix_t p;
                    p.x = int'(iX[8*m_eng +: 8]);
                    p.y = int'(iY[7*m_eng +: 7]);
                    p.c = int'(iColour[3*m_eng +: 3]);
                    if (p.x < XS && p.y < YS) begin
                        exp_q.push_back(p);
                        exp_plot = 1;
                    end
                    if (iLast[m_eng]) fin = 1;
                end
                if (!iReq[m_eng]) fin = 1;
`ifdef PLOT_ARB_TIMEOUT_EN
                if (m_cnt == MBC - 1) fin = 1;
                m_cnt++;
`endif
                if (fin) begin
                    m_busy = 0;
                    m_ptr  = m_eng;
                end
            end
        end
        exp_grant = m_busy ? N'(1 << m_eng) : '0;
    end

    // Monitor: compare every cycle, pop a pixel whenever oPlot is up.
    always @(posedge iClock) begin
        #1;
        chk("grant", 32'(oGrant), 32'(exp_grant));
        chk("ready", 32'(oReady), 32'(exp_grant));
        chk("busy",  32'(oBusy),  32'(m_busy));
        chk("plot",  32'(oPlot),  32'(exp_plot));
        if (oPlot) begin
            if (exp_q.size() == 0) begin
                chk("pixel_extra", 32'(1), 32'(0));
            end else begin
                pix_t p;
                p = exp_q.pop_front();
                chk("pixel", {9'd0, oX, oY, oColour, 5'd0},
                    {9'd0, 8'(p.x), 7'(p.y), 3'(p.c), 5'd0});
            end
        end
    end

    bit act[N];
    int rem[N];

    task automatic drive_cycle(input int req_pct);
        @(negedge iClock);
        for (int i = 0; i < N; i++) begin
            bit v;
            if (!act[i]) begin
                if ($urandom_range(0, 99) < req_pct) begin
                    act[i] = 1;
                    rem[i] = $urandom_range(1, 16);
                end
            end else if ($urandom_range(0, 29) == 0) begin
                act[i] = 0;
            end
            v = act[i] && ($urandom_range(0, 3) != 0);
            iReq[i]   = act[i];
            iValid[i] = v;
            iLast[i]  = v ? (rem[i] == 1) : ($urandom_range(0, 7) == 0);
            iX[8*i +: 8] = ($urandom_range(0, 3) == 0) ?
                           8'($urandom_range(150, 170)) :
                           8'($urandom_range(0, 255));
            iY[7*i +: 7] = ($urandom_range(0, 3) == 0) ?
                           7'($urandom_range(110, 127)) :
                           7'($urandom_range(0, 127));
            iColour[3*i +: 3] = 3'($urandom_range(0, 7));
        end
        for (int i = 0; i < N; i++) begin
            if (iValid[i] && oReady[i]) begin
                rem[i]--;
                if (rem[i] == 0) act[i] = 0;
            end
        end
    endtask

    task automatic clear_engines();
        for (int i = 0; i < N; i++) begin
            act[i] = 0;
            rem[i] = 0;
        end
        iReq   = '0;
        iValid = '0;
        iLast  = '0;
    endtask

    initial begin
        clear_engines();
        repeat (3) @(posedge iClock);
        #2;
        chk("rst_grant", 32'(oGrant), 32'(0));
        chk("rst_xyc", {13'd0, oX, oY, oColour, 1'b0}, 32'(0));
        @(negedge iClock);
        iResetn = 1'b1;

        repeat (1500) drive_cycle(30);

        for (int r = 0; r < 3; r++) begin
            for (int w = 0; w < 100 && !oBusy; w++) drive_cycle(60);
            chk("busy_wait", 32'(oBusy), 32'(1));
            repeat ($urandom_range(1, 4)) drive_cycle(60);
            @(negedge iClock);
            #2;
            iResetn = 1'b0;
            #1;
            chk("arst_grant", 32'(oGrant), 32'(0));
            chk("arst_plot",  32'(oPlot),  32'(0));
            chk("arst_busy",  32'(oBusy),  32'(0));
            clear_engines();
            @(negedge iClock);
            iResetn = 1'b1;
            repeat (300) drive_cycle(50);
        end

        repeat (1500) drive_cycle(90);

        clear_engines();
        repeat (4) @(negedge iClock);
        chk("queue_drained", 32'(exp_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
